// File: rtl/power_iter_if.sv
// power_iter_if: handshake bundle between the power-iteration controller,
// the top-level sequencer (start/abort/busy/done/status) and the datapath
// stages (stage start/done pulses, checker verdict, vector swap).
//   slave  : controller side (drives status and stage starts)
//   master : sequencer/datapath side (drives start, abort, stage dones)
interface power_iter_if;
  logic        start, abort;
  logic        busy, done, converged_o, timed_out, error;
  logic [31:0] count_k;
  logic        load_init, swap_vector;
  logic        mult_start, norm_start, check_start;
  logic        mult_done, norm_done, check_done, converged;

  modport slave (
    input  start, abort, mult_done, norm_done, check_done, converged,
    output busy, done, converged_o, timed_out, error, count_k,
           load_init, swap_vector, mult_start, norm_start, check_start
  );

  modport master (
    output start, abort, mult_done, norm_done, check_done, converged,
    input  busy, done, converged_o, timed_out, error, count_k,
           load_init, swap_vector, mult_start, norm_start, check_start
  );
endinterface

// File: rtl/power_iter_ctrl.sv
// power_iter_ctrl: sequences MULT -> NORM -> CHECK -> UPDATE per iteration of
// the power-iteration datapath, owns the iteration counter count_k and ends a
// run on convergence, MAX_ITER, stage watchdog expiry or abort.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - power_iter_if.slave (start/abort in, status + stage handshakes)
// All outputs are registers or decodes of registered state.
module power_iter_ctrl #(
  parameter int MAX_ITER     = 100,
  parameter int STEP_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  power_iter_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_MULT, S_NORM, S_CHECK, S_UPDATE, S_FIN
  } state_e;

  // Watchdog counts 0..STEP_TIMEOUT-1 inside a stage; reaching the last
  // value without an accepted done means the stage has run STEP_TIMEOUT cycles.
  localparam int              WDW     = $clog2(STEP_TIMEOUT);
  localparam logic [WDW-1:0]  WD_LAST = WDW'(STEP_TIMEOUT - 1);
  localparam logic [31:0]     K_LAST  = 32'(MAX_ITER - 1);

  state_e          state_q, state_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic [31:0]     count_k_q, count_k_d;
  logic            conv_q, conv_d, tmo_q, tmo_d, err_q, err_d;
  logic            set_conv, set_tmo, set_err;
  logic            stage_done, accept, expire, aborting;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    set_conv   = 1'b0;
    set_tmo    = 1'b0;
    set_err    = 1'b0;
    stage_done = 1'b0;
    case (state_q)
      S_MULT:  stage_done = bus.mult_done;
      S_NORM:  stage_done = bus.norm_done;
      S_CHECK: stage_done = bus.check_done;
      default: stage_done = 1'b0;
    endcase
    // Done is ignored in the start-pulse cycle (watchdog still 0 there).
    accept   = stage_done && (wd_q != '0);
    expire   = (wd_q == WD_LAST);
    aborting = bus.abort && (state_q != S_IDLE);

    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_LOAD;
      S_LOAD:   state_d = S_MULT;
      S_MULT: begin
        if (accept)      state_d = S_NORM;
        else if (expire) begin state_d = S_FIN; set_err = 1'b1; end
      end
      S_NORM: begin
        if (accept)      state_d = S_CHECK;
        else if (expire) begin state_d = S_FIN; set_err = 1'b1; end
      end
      S_CHECK: begin
        if (accept) begin
          if (bus.converged) begin
            state_d = S_FIN; set_conv = 1'b1;
          end else if (count_k_q == K_LAST) begin
            state_d = S_FIN; set_tmo = 1'b1;
          end else begin
            state_d = S_UPDATE;
          end
        end else if (expire) begin
          state_d = S_FIN; set_err = 1'b1;
        end
      end
      S_UPDATE: state_d = S_MULT;
      S_FIN:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (aborting) begin
      state_d  = S_IDLE;
      set_conv = 1'b0;
      set_tmo  = 1'b0;
      set_err  = 1'b0;
    end
  end

  // Counter / status next values
  always_comb begin
    // Any state change restarts the watchdog, which covers entry to each stage.
    wd_d      = (state_d == state_q) ? wd_q + 1'b1 : '0;
    count_k_d = count_k_q;
    conv_d    = conv_q | set_conv;
    tmo_d     = tmo_q  | set_tmo;
    err_d     = err_q  | set_err;
    if (state_q == S_IDLE && bus.start) begin
      count_k_d = '0;
      conv_d    = 1'b0;
      tmo_d     = 1'b0;
      err_d     = 1'b0;
    end
    if (state_q == S_UPDATE && !aborting) count_k_d = count_k_q + 32'd1;
    if (aborting) begin
      conv_d = 1'b0;
      tmo_d  = 1'b0;
      err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q      <= '0;
      count_k_q <= '0;
      conv_q    <= 1'b0;
      tmo_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      count_k_q <= count_k_d;
      conv_q    <= conv_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
    end
  end

  // Output decode
  always_comb begin
    bus.busy        = (state_q != S_IDLE);
    bus.done        = (state_q == S_FIN);
    bus.load_init   = (state_q == S_LOAD);
    bus.swap_vector = (state_q == S_UPDATE);
    bus.mult_start  = (state_q == S_MULT)  && (wd_q == '0);
    bus.norm_start  = (state_q == S_NORM)  && (wd_q == '0);
    bus.check_start = (state_q == S_CHECK) && (wd_q == '0);
    bus.converged_o = conv_q;
    bus.timed_out   = tmo_q;
    bus.error       = err_q;
    bus.count_k     = count_k_q;
  end
endmodule

// File: tb/tb_power_iter_ctrl.sv
module tb_power_iter_ctrl;
  localparam int MAXI = 4;
  localparam int TO   = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  power_iter_if bus();

  power_iter_ctrl #(.MAX_ITER(MAXI), .STEP_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Run plan: per-iteration latency (cycles from start pulse to done pulse,
  // 0 = never answer) and checker verdict.
  int lat_m[MAXI], lat_n[MAXI], lat_c[MAXI];
  bit verd[MAXI];
  int abort_it;   // iteration whose check_done also carries abort (-1: none)
  bit stray;      // mult_done+norm_done pulse in the first mult_start cycle
  bit restart;    // pulse start again while busy

  // Results of the last run
  int r_done, r_swaps, r_loads;

  task automatic clear_plan();
    for (int i = 0; i < MAXI; i++) begin
      lat_m[i] = 1; lat_n[i] = 1; lat_c[i] = 1; verd[i] = 1'b0;
    end
    abort_it = -1; stray = 1'b0; restart = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.abort = 0; bus.mult_done = 0; bus.norm_done = 0;
    bus.check_done = 0; bus.converged = 0;
  endtask

  // Reference: walk the plan stage by stage. Cycle 0 is the start cycle,
  // MULT opens in cycle 2; a stage answered after L cycles lasts L+1 cycles,
  // an unanswered one lasts TO cycles and ends the run in error.
  function automatic void model(output int dcyc, output int sw, output int k,
                                output bit c_o, output bit t_o, output bit e_o);
    int cyc; int ls[3];
    cyc = 2; sw = 0; k = 0; c_o = 0; t_o = 0; e_o = 0;
    forever begin
      ls[0] = lat_m[k]; ls[1] = lat_n[k]; ls[2] = lat_c[k];
      for (int s = 0; s < 3; s++) begin
        if (ls[s] == 0 || ls[s] >= TO) begin
          dcyc = cyc + TO; e_o = 1; return;
        end
        cyc += ls[s] + 1;
      end
      if (verd[k])       begin dcyc = cyc; c_o = 1; return; end
      if (k + 1 == MAXI) begin dcyc = cyc; t_o = 1; return; end
      cyc += 1; sw++; k++;
    end
  endfunction

  // Drive one run from IDLE, answering stage starts per the plan.
  // Returns one cycle after done (DUT back in IDLE), or after abort settles.
  task automatic do_run();
    int pm, pn, pc, im, in_, ic;
    bit aborted;
    pm = 0; pn = 0; pc = 0; im = 0; in_ = 0; ic = 0; aborted = 0;
    r_done = -1; r_swaps = 0; r_loads = 0;
    for (int c = 0; c < 400; c++) begin
      idle_inputs();
      bus.start = (c == 0) || (restart && c >= 3 && c <= 5);
      if (bus.load_init)   r_loads++;
      if (bus.swap_vector) r_swaps++;
      if (bus.done) begin r_done = c; break; end
      if (aborted && !bus.busy) break;
      if (pm > 0) begin pm--; if (pm == 0) bus.mult_done = 1; end
      if (pn > 0) begin pn--; if (pn == 0) bus.norm_done = 1; end
      if (pc > 0) begin
        pc--;
        if (pc == 0) begin
          bus.check_done = 1;
          bus.converged  = verd[ic-1];
          if (abort_it == ic - 1) begin bus.abort = 1; aborted = 1; end
        end
      end
      if (bus.mult_start && im < MAXI) begin
        pm = lat_m[im];
        if (stray && im == 0) begin bus.mult_done = 1; bus.norm_done = 1; end
        im++;
      end
      if (bus.norm_start && in_ < MAXI) begin pn = lat_n[in_]; in_++; end
      if (bus.check_start && ic < MAXI) begin pc = lat_c[ic]; ic++; end
      @(posedge clk); #1;
    end
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic run_vs_model(input string tag);
    int ed, es, ek; bit ec, et, ee;
    model(ed, es, ek, ec, et, ee);
    do_run();
    n_chk++; if (r_done !== ed) $display("FAIL %s done_cycle got %0d exp %0d", tag, r_done, ed); else n_pass++;
    n_chk++; if (bus.converged_o !== ec) $display("FAIL %s converged_o got %b exp %b", tag, bus.converged_o, ec); else n_pass++;
    n_chk++; if (bus.timed_out !== et) $display("FAIL %s timed_out got %b exp %b", tag, bus.timed_out, et); else n_pass++;
    n_chk++; if (bus.error !== ee) $display("FAIL %s error got %b exp %b", tag, bus.error, ee); else n_pass++;
    n_chk++; if (bus.count_k !== 32'(ek)) $display("FAIL %s count_k got %0d exp %0d", tag, bus.count_k, ek); else n_pass++;
    n_chk++; if (r_swaps !== es) $display("FAIL %s swaps got %0d exp %0d", tag, r_swaps, es); else n_pass++;
    n_chk++; if (r_loads !== 1) $display("FAIL %s load_init_count got %0d exp 1", tag, r_loads); else n_pass++;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus.busy); else n_pass++;
    n_chk++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b exp 0", bus.done); else n_pass++;
    n_chk++; if ({bus.converged_o, bus.timed_out, bus.error} !== 3'b000)
      $display("FAIL reset_flags got %b exp 000", {bus.converged_o, bus.timed_out, bus.error}); else n_pass++;
    n_chk++; if (bus.count_k !== 32'd0) $display("FAIL reset_count_k got %0d exp 0", bus.count_k); else n_pass++;
    n_chk++; if ({bus.load_init, bus.mult_start, bus.norm_start, bus.check_start, bus.swap_vector} !== 5'b0)
      $display("FAIL reset_pulses got %b exp 00000",
               {bus.load_init, bus.mult_start, bus.norm_start, bus.check_start, bus.swap_vector}); else n_pass++;
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_converge_first();
    clear_plan(); verd[0] = 1;
    run_vs_model("conv_first");
    n_chk++; if (r_done !== 8) $display("FAIL conv_first_latency got %0d exp 8", r_done); else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (bus.converged_o !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL conv_first_hold got conv=%b busy=%b exp conv=1 busy=0", bus.converged_o, bus.busy); else n_pass++;
  endtask

  task automatic test_converge_iter3();
    clear_plan(); verd[3] = 1;
    run_vs_model("conv_iter3");
  endtask

  task automatic test_max_iter();
    clear_plan();
    lat_m[1] = 3; lat_c[2] = 2;
    run_vs_model("max_iter");
  endtask

  task automatic test_watchdog();
    clear_plan(); lat_n[0] = 0; stray = 1;
    run_vs_model("watchdog_norm");
    n_chk++; if (r_done !== 20) $display("FAIL watchdog_latency got %0d exp 20", r_done); else n_pass++;
    // Answer on the very last allowed cycle: done beats the watchdog.
    clear_plan(); lat_c[0] = TO - 1; verd[0] = 1;
    run_vs_model("watchdog_edge");
    clear_plan(); lat_m[1] = TO; verd[2] = 1;
    run_vs_model("watchdog_mult");
  endtask

  task automatic test_abort();
    clear_plan(); verd[1] = 1; abort_it = 1;
    do_run();
    n_chk++; if (r_done !== -1) $display("FAIL abort_done got cycle %0d exp none", r_done); else n_pass++;
    n_chk++; if (bus.converged_o !== 1'b0) $display("FAIL abort_conv got %b exp 0", bus.converged_o); else n_pass++;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL abort_busy got %b exp 0", bus.busy); else n_pass++;
    n_chk++; if (bus.count_k !== 32'd1) $display("FAIL abort_count_k got %0d exp 1", bus.count_k); else n_pass++;
    clear_plan(); verd[0] = 1;
    run_vs_model("after_abort");
  endtask

  task automatic test_async_reset();
    idle_inputs();
    bus.start = 1;
    @(posedge clk); #1; bus.start = 0;
    @(posedge clk); #1;
    n_chk++; if (bus.mult_start !== 1'b1) $display("FAIL areset_in_mult got %b exp 1", bus.mult_start); else n_pass++;
    #2 rst = 0;
    #1;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL areset_busy got %b exp 0", bus.busy); else n_pass++;
    n_chk++; if ({bus.done, bus.mult_start, bus.load_init, bus.swap_vector} !== 4'b0)
      $display("FAIL areset_pulses got %b exp 0000", {bus.done, bus.mult_start, bus.load_init, bus.swap_vector}); else n_pass++;
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    clear_plan(); verd[1] = 1; restart = 1;
    run_vs_model("start_while_busy");
  endtask

  task automatic test_random();
    for (int r = 0; r < 20; r++) begin
      clear_plan();
      for (int i = 0; i < MAXI; i++) begin
        lat_m[i] = ($urandom_range(0, 24) == 0) ? 0 : $urandom_range(1, 4);
        lat_n[i] = ($urandom_range(0, 9) == 0)  ? TO - 1 : $urandom_range(1, 4);
        lat_c[i] = ($urandom_range(0, 24) == 0) ? 0 : $urandom_range(1, 4);
        verd[i]  = ($urandom_range(0, 3) == 0);
      end
      restart = $urandom_range(0, 1);
      stray   = $urandom_range(0, 1);
      run_vs_model($sformatf("random%0d", r));
    end
  endtask

  initial begin
    test_reset();
    test_converge_first();
    test_converge_iter3();
    test_max_iter();
    test_watchdog();
    test_abort();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1);
  end
endmodule
